mult32_seq_ctrl: RTL

- Multi-cycle controller for 32x32 MULT/MULTU in the MIPS32 execute stage.
- Time-shares one external combinational 24x28 Wallace product unit (52-bit result) over up to four passes.
- Accumulates the passes into a 64-bit result and writes HI/LO.
- Sequences operand slices, drives the shared unit's inputs, and handshakes with the pipeline via start/busy/done.

---
 rtl/mult32_seq_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mult32_seq_ctrl.sv
// Sequential 32x32 MULT/MULTU controller sharing one 24x28 product unit.
// Optional signed support is enabled by defining MULT_SIGNED_EN.
module mult32_seq_ctrl #(
    parameter int EARLY_OUT = 1,
    parameter int ACC_W     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_signed,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [23:0] mul_a,
    output logic [27:0] mul_b,
    input  logic [51:0] mul_z
);

    typedef enum logic [1:0] {IDLE, PASS, FIN} state_e;

    state_e             state_q, state_d;
    logic [1:0]         p_q, p_d;
    logic [31:0]        ma_q, mb_q;
    logic [31:0]        ma_in, mb_in;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   addend, res;
    logic [31:0]        hi_q, lo_q;
    logic [5:0]         sh;
    logic               load, fin_en, early;

`ifdef MULT_SIGNED_EN
    logic neg_q, neg_in;

    always_comb begin
        ma_in  = (op_signed & rs_val[31]) ? (32'd0 - rs_val) : rs_val;
        mb_in  = (op_signed & rt_val[31]) ? (32'd0 - rt_val) : rt_val;
        neg_in = op_signed & (rs_val[31] ^ rt_val[31]);
        res    = neg_q ? (~acc_d + 1'b1) : acc_d;
    end
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;

    always_comb begin
        ma_in = rs_val;
        mb_in = rt_val;
        res   = acc_d;
    end
`endif

    // Slice selection per pass; the unit is held at zero outside PASS.
    always_comb begin
        mul_a = 24'd0;
        mul_b = 28'd0;
        sh    = 6'd0;
        if (state_q == PASS) begin
            unique case (p_q)
                2'd0: begin
                    mul_a = ma_q[23:0];
                    mul_b = mb_q[27:0];
                    sh    = 6'd0;
                end
                2'd1: begin
                    mul_a = ma_q[23:0];
                    mul_b = {24'd0, mb_q[31:28]};
                    sh    = 6'd28;
                end
                2'd2: begin
                    mul_a = {16'd0, ma_q[31:24]};
                    mul_b = mb_q[27:0];
                    sh    = 6'd24;
                end
                default: begin
                    mul_a = {16'd0, ma_q[31:24]};
                    mul_b = {24'd0, mb_q[31:28]};
                    sh    = 6'd52;
                end
            endcase
        end
    end

    assign addend = {{(ACC_W-52){1'b0}}, mul_z} << sh;
    assign early  = (EARLY_OUT != 0) && (ma_q[31:24] == 8'd0)
                    && (mb_q[31:28] == 4'd0);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        acc_d   = acc_q;
        load    = 1'b0;
        fin_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    p_d     = 2'd0;
                    state_d = PASS;
                end
            end
            PASS: begin
                acc_d = acc_q + addend;
                if (p_q == 2'd3 || (p_q == 2'd0 && early)) begin
                    fin_en  = 1'b1;
                    state_d = FIN;
                end else begin
                    p_d = p_q + 2'd1;
                end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= 2'd0;
            ma_q    <= 32'd0;
            mb_q    <= 32'd0;
            acc_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            if (load) begin
                ma_q <= ma_in;
                mb_q <= mb_in;
            end
            if (fin_en) begin
                hi_q <= res[63:32];
                lo_q <= res[31:0];
            end
        end
    end

`ifdef MULT_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    neg_q <= 1'b0;
        else if (load) neg_q <= neg_in;
    end
`endif

    assign busy = (state_q == PASS);
    assign done = (state_q == FIN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
